// File: rtl/stream_bram_bridge_s.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stream_bram_bridge_s                                                       |
// | AXI-Stream to banked BRAM bridge: instruction-driven linear read/write.    |
// | Optional error flag: define STREAM_BRIDGE_S_ERR_EN.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stream_bram_bridge_s #(
   parameter int         DATA_W     = 128,
   parameter int         NBANK      = 2,
   parameter int         BANK_DEPTH = 12544,
   parameter int         LADDR_W    = 14,
   parameter logic [1:0] RMODE      = 2'b01,
   parameter logic [1:0] WMODE      = 2'b00
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [63:0]                  s_instruct_tdata,
   input  logic                         s_instruct_tvalid,
   output logic                         s_instruct_tready,
   input  logic [DATA_W-1:0]            s_in_tdata,
   input  logic                         s_in_tvalid,
   output logic                         s_in_tready,
   input  logic [DATA_W/8-1:0]          s_in_tkeep,
   input  logic                         s_in_tlast,
   output logic [DATA_W-1:0]            m_out_tdata,
   output logic                         m_out_tvalid,
   input  logic                         m_out_tready,
   output logic [DATA_W/8-1:0]          m_out_tkeep,
   output logic                         m_out_tlast,
   output logic                         weight_switch,
   output logic                         done,
   output logic                         err,
   output logic [NBANK*LADDR_W-1:0]     bram_addr,
   output logic [DATA_W-1:0]            bram_din,
   input  logic [NBANK*DATA_W-1:0]      bram_dout,
   output logic [NBANK*DATA_W/8-1:0]    bram_we
);
   localparam int c_keep_w = DATA_W / 8;
   localparam int c_bank_w = $clog2(NBANK + 1);
   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_read  = 2'd1;
   localparam logic [1:0] c_write = 2'd2;
   localparam logic [c_bank_w-1:0] c_oor  = c_bank_w'(NBANK);
   localparam logic [LADDR_W-1:0]  c_wrap = LADDR_W'(BANK_DEPTH - 1);

   logic [1:0]          r_state, w_next;
   logic                r_live, r_done, r_rv;
   logic [14:0]         r_len, r_icnt, r_ocnt;
   logic [c_bank_w-1:0] r_bank, r_rbank, w_bank;
   logic [LADDR_W-1:0]  r_local, w_local;
   logic [31:0]         w_local_full;
   logic [1:0]          r_cnt;
   logic [DATA_W-1:0]   r_b0, r_b1, w_rdata;
   logic [14:0]         w_start, w_len;
   logic [1:0]          w_mode;
   logic                w_acc, w_mode_ok, w_go, w_zero, w_exit;
   logic                w_issue, w_pop, w_wr_fire, w_wr_end, w_rd_end, w_adv, w_oor;
   logic                w_unused;

   assign w_len     = s_instruct_tdata[14:0];
   assign w_start   = s_instruct_tdata[29:15];
   assign w_mode    = s_instruct_tdata[31:30];
   assign w_acc     = s_instruct_tvalid & s_instruct_tready;
   assign w_mode_ok = (w_mode == RMODE) || (w_mode == WMODE);
   assign w_go      = w_acc && w_mode_ok && (w_len != 15'd0);
   assign w_zero    = w_acc && w_mode_ok && (w_len == 15'd0);
   assign w_unused  = ^{s_instruct_tdata[63:34], s_instruct_tdata[32], w_local_full[31:LADDR_W]};

   // Global start address -> (bank, local); bank NBANK marks out-of-range.
   always_comb begin
      w_bank = '0;
      for (int k = 1; k <= NBANK; k++) begin
         if ({17'd0, w_start} >= 32'(k * BANK_DEPTH)) w_bank = c_bank_w'(k);
      end
      w_local_full = {17'd0, w_start} - (32'(w_bank) * 32'(BANK_DEPTH));
      w_local      = w_local_full[LADDR_W-1:0];
   end

   assign w_oor     = (r_bank == c_oor);
   assign w_pop     = m_out_tvalid & m_out_tready;
   assign w_issue   = (r_state == c_read) && (r_icnt != r_len) && ((r_cnt + {1'b0, r_rv}) < 2'd2);
   assign w_rd_end  = (r_state == c_read) && w_pop && ((r_ocnt + 15'd1) == r_len);
   assign w_wr_fire = (r_state == c_write) && s_in_tvalid;
   assign w_wr_end  = w_wr_fire && (s_in_tlast || ((r_ocnt + 15'd1) == r_len));
   assign w_adv     = w_issue | w_wr_fire;
   assign w_exit    = (r_state != c_idle) && (w_next == c_idle);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= c_idle;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle:  if (w_go) w_next = (w_mode == RMODE) ? c_read : c_write;
         c_read:  if (w_rd_end) w_next = c_idle;
         c_write: if (w_wr_end) w_next = c_idle;
         default: w_next = c_idle;
      endcase
   end

   always_comb begin
      s_instruct_tready = (r_state == c_idle) && r_live;
      s_in_tready       = (r_state == c_write);
      bram_din          = (r_state == c_write) ? s_in_tdata : '0;
   end

   always_comb begin
      w_rdata = '0;
      for (int k = 0; k < NBANK; k++) begin
         if (r_rbank == c_bank_w'(k)) w_rdata = bram_dout[k*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_live <= 1'b0;   r_done <= 1'b0;  weight_switch <= 1'b0;
         r_len <= '0;      r_icnt <= '0;    r_ocnt <= '0;
         r_bank <= '0;     r_local <= '0;   r_rbank <= '0;
         r_rv <= 1'b0;     r_cnt <= '0;     r_b0 <= '0;   r_b1 <= '0;
      end else begin
         r_live <= 1'b1;
         r_done <= w_exit | w_zero;
         r_rv   <= w_issue;
         if (w_issue) begin
            r_rbank <= r_bank;
            r_icnt  <= r_icnt + 15'd1;
         end
         if (w_pop || w_wr_fire) r_ocnt <= r_ocnt + 15'd1;
         if (w_go) begin
            r_len <= w_len;  weight_switch <= s_instruct_tdata[33];
            r_bank <= w_bank; r_local <= w_local;
            r_icnt <= '0;     r_ocnt <= '0;
         end else if (w_exit) begin
            r_len <= '0;      weight_switch <= 1'b0;
         end
         if (w_adv) begin
            if (r_local == c_wrap) begin
               r_local <= '0;
               if (!w_oor) r_bank <= r_bank + 1'b1;
            end else begin
               r_local <= r_local + 1'b1;
            end
         end
         // Skid buffer: head in r_b0; a push and pop together keep occupancy.
         case (r_cnt)
            2'd0: if (r_rv && !w_pop) begin r_b0 <= w_rdata; r_cnt <= 2'd1; end
            2'd1: begin
               if (r_rv && w_pop)  r_b0 <= w_rdata;
               else if (r_rv)      begin r_b1 <= w_rdata; r_cnt <= 2'd2; end
               else if (w_pop)     r_cnt <= 2'd0;
            end
            default: if (w_pop) begin
               r_b0 <= r_b1;
               if (r_rv) r_b1 <= w_rdata;
               else      r_cnt <= 2'd1;
            end
         endcase
      end
   end

   assign m_out_tvalid = (r_cnt != 2'd0) || r_rv;
   assign m_out_tdata  = (r_cnt != 2'd0) ? r_b0 : (r_rv ? w_rdata : '0);
   assign m_out_tlast  = m_out_tvalid && (r_state == c_read) && ((r_ocnt + 15'd1) == r_len);
   assign m_out_tkeep  = '1;
   assign done         = r_done;

   generate
      for (genvar k = 0; k < NBANK; k++) begin : g_bank
         assign bram_addr[k*LADDR_W +: LADDR_W] = r_local;
         assign bram_we[k*c_keep_w +: c_keep_w] =
            (w_wr_fire && (r_bank == c_bank_w'(k))) ? s_in_tkeep : '0;
      end
   endgenerate

`ifdef STREAM_BRIDGE_S_ERR_EN
   logic r_err;
   always_ff @(posedge clk) begin
      if (!rst_n) r_err <= 1'b0;
      else if ((w_acc && !w_mode_ok) || (w_adv && w_oor) ||
               (w_wr_fire && s_in_tlast && ((r_ocnt + 15'd1) != r_len)))
         r_err <= 1'b1;
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif
endmodule
`default_nettype wire
